// File: rtl/band_mag_avg.sv
// rtl/band_mag_avg.sv - per-band windowed sample magnitude average with peak-hold and linear decay
// One instance per band; avg_mag feeds the band's 15-bit thermometer/LED encoder.
module band_mag_avg #(
  parameter int          LOG2_WIN = 10,
  parameter logic [14:0] DECAY    = 15'h0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] smpl_in,
  input  logic        smpl_vld,
  output logic [14:0] avg_mag,
  output logic        avg_rdy
);

  localparam int AW = 15 + LOG2_WIN;

  logic [AW-1:0]       acc;
  logic [LOG2_WIN-1:0] cnt;

  logic [14:0]   mag;
  logic [AW-1:0] sum;
  logic [14:0]   avg;
  logic [14:0]   decayed;
  logic [14:0]   held;
  logic          last;

  // Most-negative sample has no positive counterpart in 15 bits; clamp it.
  always_comb begin
    mag = smpl_in[14:0];
    if (smpl_in[15]) begin
      if (smpl_in[14:0] == 15'd0) mag = 15'h7FFF;
      else                        mag = ~smpl_in[14:0] + 15'd1;
    end
  end

  always_comb begin
    sum  = acc + {{LOG2_WIN{1'b0}}, mag};
    avg  = sum[AW-1:LOG2_WIN];
    last = &cnt;
  end

  // Decay floors at zero; the new window can still pull the bar up above the decayed level.
  always_comb begin
    decayed = (avg_mag > DECAY) ? (avg_mag - DECAY) : 15'd0;
    held    = avg;
    if ((DECAY != 15'd0) && (avg < avg_mag)) begin
      held = (decayed > avg) ? decayed : avg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      avg_mag <= '0;
      avg_rdy <= 1'b0;
    end else begin
      avg_rdy <= 1'b0;
      if (smpl_vld) begin
        if (last) begin
          acc     <= '0;
          cnt     <= '0;
          avg_mag <= held;
          avg_rdy <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
